// File: rtl/usr_seq_ctrl.sv
// Sequencer for a universal shift register (USR): accepts a load-and-shift command,
// drives the USR select/data lines through load, shift and capture, then presents the
// captured USR value on a valid/ready result interface.
// Optional feature: define USR_SEQ_ABORT_EN to add a synchronous abort input.
module usr_seq_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef USR_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [WIDTH-1:0] usr_d_in,
  output logic [1:0]       usr_select,
  input  logic [WIDTH-1:0] usr_q,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready
);

  // Counter must hold values 0..WIDTH inclusive.
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] SelHold  = 2'b00;
  localparam logic [1:0] SelRight = 2'b01;
  localparam logic [1:0] SelLeft  = 2'b10;
  localparam logic [1:0] SelLoad  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StCapt,
    StResp
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    eff_cnt;
  logic             abort_act;

`ifdef USR_SEQ_ABORT_EN
  assign abort_act = abort;
`else
  assign abort_act = 1'b0;
`endif

  // Clamp the requested shift count to the register width.
  always_comb begin
    if (32'(cmd_count) > WIDTH) begin
      eff_cnt = CW'(WIDTH);
    end else begin
      eff_cnt = CW'(cmd_count);
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    dir_d        = dir_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    usr_select   = SelHold;
    cmd_ready    = 1'b0;
    result_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Abort has no effect here, so an accept proceeds normally.
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          data_d  = cmd_data;
          dir_d   = cmd_dir;
          cnt_d   = eff_cnt;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (abort_act) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          usr_select = SelLoad;
          state_d    = (cnt_q != '0) ? StShift : StCapt;
        end
      end
      StShift: begin
        if (abort_act) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          usr_select = dir_q ? SelLeft : SelRight;
          cnt_d      = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = StCapt;
          end
        end
      end
      StCapt: begin
        // USR holds during this cycle, so usr_q is the final shifted value.
        if (abort_act) begin
          state_d = StIdle;
        end else begin
          result_d = usr_q;
          state_d  = StResp;
        end
      end
      StResp: begin
        if (abort_act) begin
          state_d = StIdle;
        end else begin
          result_valid = 1'b1;
          if (result_ready) begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset abandons any sequence in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      data_q   <= '0;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign usr_d_in = data_q;
  assign result   = result_q;

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Self-checking bench for usr_seq_ctrl with a behavioural 8-bit USR (zero fill on shift).
// Expected results are pushed to a scoreboard queue at command issue and popped when the
// controller presents its result.
module tb_usr_seq_ctrl;

  localparam int W   = 8;
  localparam int CNT = 4;

  logic           clk = 1'b0;
  logic           rst;
`ifdef USR_SEQ_ABORT_EN
  logic           abort;
`endif
  logic           cmd_valid;
  logic           cmd_ready;
  logic [W-1:0]   cmd_data;
  logic           cmd_dir;
  logic [CNT-1:0] cmd_count;
  logic [W-1:0]   usr_d_in;
  logic [1:0]     usr_select;
  logic [W-1:0]   usr_q;
  logic [W-1:0]   result;
  logic           result_valid;
  logic           result_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  usr_seq_ctrl #(
    .WIDTH (W),
    .CNT_W (CNT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef USR_SEQ_ABORT_EN
    .abort        (abort),
`endif
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_data     (cmd_data),
    .cmd_dir      (cmd_dir),
    .cmd_count    (cmd_count),
    .usr_d_in     (usr_d_in),
    .usr_select   (usr_select),
    .usr_q        (usr_q),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  // Behavioural universal shift register.
  always_ff @(posedge clk) begin
    case (usr_select)
      2'b01:   usr_q <= {1'b0, usr_q[W-1:1]};
      2'b10:   usr_q <= {usr_q[W-2:0], 1'b0};
      2'b11:   usr_q <= usr_d_in;
      default: usr_q <= usr_q;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_result(input logic [W-1:0] data, input logic dir,
                                                input int count);
    logic [W-1:0] v;
    int           eff;
    v   = data;
    eff = (count > W) ? W : count;
    for (int i = 0; i < eff; i++) begin
      v = dir ? {v[W-2:0], 1'b0} : {1'b0, v[W-1:1]};
    end
    return v;
  endfunction

  // Caller is at a negedge with the controller in IDLE.
  task automatic run_cmd(input logic [W-1:0] data, input logic dir, input logic [CNT-1:0] count,
                         input int hold, input bit early_ready);
    logic [1:0]   trace[$];
    logic [W-1:0] exp_res;
    int           eff;
    eff = (int'(count) > W) ? W : int'(count);
    trace.push_back(2'b11);
    repeat (eff) trace.push_back(dir ? 2'b10 : 2'b01);
    trace.push_back(2'b00);

    check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_data  = data;
    cmd_dir   = dir;
    cmd_count = count;
    exp_q.push_back(model_result(data, dir, int'(count)));
    @(posedge clk);
    @(negedge clk);
    cmd_valid    = 1'b0;
    cmd_data     = ~data;
    result_ready = early_ready;

    for (int i = 0; i < trace.size(); i++) begin
      check_eq($sformatf("sel[%0d]", i), 32'(usr_select), 32'(trace[i]));
      check_eq("rv_before_resp", 32'(result_valid), 32'd0);
      check_eq("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      if (i == 0) check_eq("d_in_load", 32'(usr_d_in), 32'(data));
      @(negedge clk);
    end

    check_eq("rv_resp", 32'(result_valid), 32'd1);
    check_eq("sel_resp", 32'(usr_select), 32'd0);
    check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    exp_res = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check_eq("result", 32'(result), 32'(exp_res));

    for (int k = 0; k < hold; k++) begin
      result_ready = 1'b0;
      cmd_valid    = k[0];
      @(posedge clk);
      @(negedge clk);
      check_eq("rv_hold", 32'(result_valid), 32'd1);
      check_eq("result_hold", 32'(result), 32'(exp_res));
      check_eq("cmd_ready_hold", 32'(cmd_ready), 32'd0);
      check_eq("d_in_hold", 32'(usr_d_in), 32'(data));
    end
    cmd_valid = 1'b0;

    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    result_ready = 1'b0;
    check_eq("rv_after", 32'(result_valid), 32'd0);
    check_eq("cmd_ready_after", 32'(cmd_ready), 32'd1);
    check_eq("sel_idle", 32'(usr_select), 32'd0);
    check_eq("d_in_idle", 32'(usr_d_in), 32'(data));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
`ifdef USR_SEQ_ABORT_EN
    abort        = 1'b0;
`endif
    cmd_valid    = 1'b0;
    cmd_data     = '0;
    cmd_dir      = 1'b0;
    cmd_count    = '0;
    result_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_sel", 32'(usr_select), 32'd0);
    check_eq("rst_d_in", 32'(usr_d_in), 32'd0);
    check_eq("rst_result", 32'(result), 32'd0);
    check_eq("rst_rv", 32'(result_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Load-only, shift left 2, clamped shift right, backpressure, early ready.
    run_cmd(8'b1010_0000, 1'b0, 4'd0, 0, 1'b0);
    run_cmd(8'b0000_1100, 1'b1, 4'd2, 0, 1'b0);
    run_cmd(8'hFF, 1'b0, 4'd15, 0, 1'b0);
    run_cmd(8'h81, 1'b1, 4'd3, 4, 1'b0);
    run_cmd(8'h3C, 1'b0, 4'd1, 0, 1'b1);
    run_cmd(8'h96, 1'b1, 4'd8, 1, 1'b0);

    // Reset in the second SHIFT cycle of a count-5 command.
    cmd_valid = 1'b1;
    cmd_data  = 8'h5A;
    cmd_dir   = 1'b1;
    cmd_count = 4'd5;
    exp_q.push_back(model_result(8'h5A, 1'b1, 5));
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("rstseq_load", 32'(usr_select), 32'd3);
    @(negedge clk);
    check_eq("rstseq_shift1", 32'(usr_select), 32'd2);
    @(negedge clk);
    check_eq("rstseq_shift2", 32'(usr_select), 32'd2);
    #1 rst = 1'b1;
    #1;
    check_eq("rstseq_sel", 32'(usr_select), 32'd0);
    check_eq("rstseq_rv", 32'(result_valid), 32'd0);
    check_eq("rstseq_d_in", 32'(usr_d_in), 32'd0);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rstseq_ready", 32'(cmd_ready), 32'd1);
    check_eq("rstseq_rv_idle", 32'(result_valid), 32'd0);
    run_cmd(8'h0F, 1'b1, 4'd4, 0, 1'b0);

`ifdef USR_SEQ_ABORT_EN
    // Abort during SHIFT: select drops at once, no result follows.
    cmd_valid = 1'b1;
    cmd_data  = 8'hF0;
    cmd_dir   = 1'b1;
    cmd_count = 4'd5;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_pre_sel", 32'(usr_select), 32'd2);
    abort = 1'b1;
    #1;
    check_eq("abort_sel", 32'(usr_select), 32'd0);
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_ready", 32'(cmd_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      check_eq("abort_rv", 32'(result_valid), 32'd0);
      @(negedge clk);
    end
    run_cmd(8'h11, 1'b0, 4'd1, 0, 1'b0);
`endif

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/usr_seq_ctrl.md
USR_SEQ_CTRL -- requirements
Module: usr_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: data width of the sequenced universal shift register (USR).
REQ-002 Parameter CNT_W, default 4: width of the shift-count field.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  controller can accept a command.
REQ-007 cmd_data  input  WIDTH  value to parallel-load into the USR.
REQ-008 cmd_dir  input  1  0 = shift right, 1 = shift left.
REQ-009 cmd_count  input  CNT_W  number of shift cycles after the load.
REQ-010 usr_d_in  output  WIDTH  drives USR d_in.
REQ-011 usr_select  output  2  drives USR select: 00 hold, 01 right, 10 left, 11 load.
REQ-012 usr_q  input  WIDTH  USR q, observed by the controller.
REQ-013 result  output  WIDTH  captured final USR value.
REQ-014 result_valid  output  1  result available.
REQ-015 result_ready  input  1  consumer accepts result.
REQ-016 abort  input  1  synchronous abort. Present only with USR_SEQ_ABORT_EN.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, SHIFT, CAPT and RESP.
REQ-018 cmd_ready SHALL be 1 only in IDLE. A command is accepted on an edge where cmd_valid&cmd_ready=1.
REQ-019 On accept, the FSM SHALL latch cmd_data, cmd_dir and eff_cnt = min(cmd_count, WIDTH), then go to LOAD.
REQ-020 In LOAD: usr_select=11 and usr_d_in=latched data for exactly one cycle. Next state is SHIFT if eff_cnt>0, else CAPT.
REQ-021 In SHIFT: usr_select=10 if dir=1, else 01, for exactly eff_cnt consecutive cycles (internal down-counter), then CAPT.
REQ-022 In CAPT: usr_select=00 for one cycle. result SHALL be registered from usr_q at the end of that cycle, then go to RESP.
REQ-023 In RESP: result_valid=1 and usr_select=00. result is held stable. Go to IDLE on the edge where result_ready=1.
REQ-024 In IDLE, CAPT and RESP, usr_select SHALL be 00. usr_d_in SHALL hold the last latched data (0 after reset).
REQ-025 Latency: the accept edge to the first cycle with result_valid=1 SHALL be eff_cnt+3 cycles.
REQ-026 cmd_valid while not IDLE SHALL be ignored; there is no queuing.
REQ-027 result_ready while not in RESP SHALL be ignored.
REQ-028 Back-to-back: a command may be accepted on the first IDLE cycle after RESP exits.
REQ-029 cmd_count > WIDTH SHALL be clamped to WIDTH. cmd_count=0 SHALL perform load-only.

Reset
REQ-030 rst=1 SHALL immediately force: state IDLE, usr_select=00, usr_d_in=0, result=0, result_valid=0, shift counter 0, cmd_ready=1 once rst deasserts.
REQ-031 Reset asserted mid-sequence SHALL abandon the sequence; no result is produced.

Configuration
REQ-032 Macro USR_SEQ_ABORT_EN, when defined, SHALL add the abort port.
REQ-033 abort=1 in LOAD, SHIFT or CAPT SHALL force usr_select=00 on that cycle and go to IDLE next edge, with no result_valid.
REQ-034 abort in RESP SHALL drop result_valid and go to IDLE. abort in IDLE SHALL have no effect. abort has priority over a simultaneous cmd_valid or result_ready.
REQ-035 Without USR_SEQ_ABORT_EN, the abort port SHALL be absent and the sequencing otherwise identical.

Verification
All scenarios use a behavioural 8-bit USR model (zero fill on shift) connected to usr_d_in, usr_select and usr_q, with WIDTH=8.
REQ-036 Load-only: cmd_data=8'b1010_0000, cmd_count=0 -> result_valid 3 cycles after accept; result=1010_0000; select trace 11,00,00.
REQ-037 Shift left 2: data=8'b0000_1100, dir=1, count=2 -> select trace 11,10,10,00; result=0011_0000 after 5 cycles.
REQ-038 Shift right, clamped: data=8'hFF, dir=0, count=15 -> exactly 8 cycles of select=01; result=8'h00.
REQ-039 Backpressure: hold result_ready=0 for 4 cycles -> result and result_valid stable; cmd_valid pulses ignored and cmd_ready=0 throughout.
REQ-040 Reset during SHIFT (cycle 2 of count=5) -> usr_select=00 and result_valid=0 immediately; next command completes normally.
REQ-041 USR_SEQ_ABORT_EN defined, abort in SHIFT -> usr_select=00 the same cycle; IDLE next; no result_valid; cmd_ready=1.
